sol_reporter: RTL and testbench

- Responder side of the miner controller's sol_claim / sol_response handshake.
- On a claim it latches the candidate nonce and sends a framed report (SOF byte plus nonce bytes) to the host over a byte-wide valid/ready link.
- It then waits for the host verdict and returns a one-cycle sol_response code that releases the controller from HALT.
- An abort on start_found or a verdict timeout keeps the miner from stalling.

---
 rtl/miner_pkg.sv | 27 ++
 rtl/nonce_serializer.sv | 50 +++++
 rtl/sol_reporter.sv | 122 ++++++++++++
 tb/tb_sol_reporter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner controller / solution reporter pair.
package miner_pkg;

  // Reporter FSM states; encodings are exposed on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'b000,
    ST_SEND_SOF     = 3'b001,
    ST_SEND_NONCE   = 3'b010,
    ST_WAIT_VERDICT = 3'b011,
    ST_RESPOND      = 3'b100
  } rep_state_t;

  // sol_response codes, also decoded by the controller.
  localparam logic [1:0] RESP_WAIT   = 2'b00;
  localparam logic [1:0] RESP_RESUME = 2'b01;
  localparam logic [1:0] RESP_DONE   = 2'b10;

  // Start-of-frame marker; the host resynchronises on this byte.
  localparam logic [7:0] FRAME_SOF = 8'hA5;

  // Verdict held from WAIT_VERDICT into RESPOND.
  typedef struct packed {
    logic [1:0] code;
    logic       timeout;
  } verdict_t;

endpackage

// File: rtl/nonce_serializer.sv
// Holds the claimed nonce and presents it one byte at a time, MSB first.
module nonce_serializer
  import miner_pkg::*;
#(
  parameter int NONCE_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_load,
  input  logic                     i_clr,
  input  logic                     i_advance,
  input  logic [8*NONCE_BYTES-1:0] i_nonce,
  output logic [7:0]               o_byte,
  output logic                     o_last_byte
);

  localparam int IW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NONCE_BYTES - 1);

  logic [8*NONCE_BYTES-1:0] r_nonce;
  logic [IW-1:0]            r_idx;
  logic [7:0]               w_byte;

  // Nonce latch and byte index; index wraps to 0 after the last byte so it is ready for the next frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nonce <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_nonce <= i_nonce;
      r_idx   <= '0;
    end else if (i_clr) begin
      r_idx   <= '0;
    end else if (i_advance) begin
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Byte mux: index 0 selects the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    for (int b = 0; b < NONCE_BYTES; b++) begin
      if (r_idx == IW'(NONCE_BYTES - 1 - b)) w_byte = r_nonce[8*b +: 8];
    end
  end

  assign o_byte      = w_byte;
  assign o_last_byte = (r_idx == LAST_IDX);

endmodule

// File: rtl/sol_reporter.sv
// Solution reporter: frames a claimed nonce to the host, waits for its
// verdict (or a timeout) and returns a one-cycle response code.
module sol_reporter
  import miner_pkg::*;
#(
  parameter int NONCE_BYTES    = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_start_found,
  input  logic                     i_sol_claim,
  input  logic [8*NONCE_BYTES-1:0] i_sol_nonce,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  input  logic                     i_host_ack,
  input  logic                     i_host_nack,
  output logic [1:0]               o_sol_response,
  output logic                     o_sol_timeout,
  output logic                     o_busy,
  output logic [2:0]               o_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  rep_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt;
  verdict_t      r_verdict, w_verdict_d;
  logic          w_load, w_clr, w_adv, w_cnt_clr;
  logic [7:0]    w_byte;
  logic          w_last;

  nonce_serializer #(.NONCE_BYTES(NONCE_BYTES)) u_ser (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_load      (w_load),
    .i_clr       (w_clr),
    .i_advance   (w_adv),
    .i_nonce     (i_sol_nonce),
    .o_byte      (w_byte),
    .o_last_byte (w_last)
  );

  // State, verdict and timeout counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_verdict <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_verdict <= w_verdict_d;
      // Hold at the last value on exit so the counter never wraps.
      if (w_cnt_clr)                                           r_cnt <= '0;
      else if (r_state == ST_WAIT_VERDICT && w_next == ST_WAIT_VERDICT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state and control; start_found overrides everything at the end.
  always_comb begin
    w_next      = r_state;
    w_verdict_d = r_verdict;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sol_claim) begin
          w_next = ST_SEND_SOF;
          w_load = 1'b1;
        end
      end
      ST_SEND_SOF: begin
        if (i_tx_ready) w_next = ST_SEND_NONCE;
      end
      ST_SEND_NONCE: begin
        if (i_tx_ready) begin
          w_adv = 1'b1;
          if (w_last) begin
            w_next    = ST_WAIT_VERDICT;
            w_cnt_clr = 1'b1;
          end
        end
      end
      ST_WAIT_VERDICT: begin
        // A real verdict beats a timeout landing on the same cycle.
        if (i_host_ack || i_host_nack) begin
          w_verdict_d.code    = i_host_nack ? RESP_RESUME : RESP_DONE;
          w_verdict_d.timeout = 1'b0;
          w_next              = ST_RESPOND;
        end else if (r_cnt == CNT_LAST) begin
          w_verdict_d.code    = RESP_RESUME;
          w_verdict_d.timeout = 1'b1;
          w_next              = ST_RESPOND;
        end
      end
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (i_start_found) begin
      w_next      = ST_IDLE;
      w_verdict_d = '0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_clr       = 1'b1;
      w_cnt_clr   = 1'b1;
    end
  end

  // Outputs decode from state and registers only.
  assign o_state        = r_state;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_tx_valid     = (r_state == ST_SEND_SOF) || (r_state == ST_SEND_NONCE);
  assign o_tx_data      = (r_state == ST_SEND_SOF)   ? FRAME_SOF :
                          (r_state == ST_SEND_NONCE) ? w_byte    : 8'h00;
  assign o_sol_response = (r_state == ST_RESPOND) ? r_verdict.code : RESP_WAIT;
  assign o_sol_timeout  = (r_state == ST_RESPOND) && r_verdict.timeout;

endmodule

// File: tb/tb_sol_reporter.sv
// Directed bench for sol_reporter: a cycle-by-cycle vector table plus a reset sequence.
module tb_sol_reporter;

  logic        clk, n_rst;
  logic        start_found, sol_claim, tx_ready, host_ack, host_nack;
  logic [31:0] sol_nonce;
  logic [7:0]  tx_data;
  logic        tx_valid, sol_timeout, busy;
  logic [1:0]  sol_response;
  logic [2:0]  state;

  sol_reporter #(.NONCE_BYTES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_start_found  (start_found),
    .i_sol_claim    (sol_claim),
    .i_sol_nonce    (sol_nonce),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .i_host_ack     (host_ack),
    .i_host_nack    (host_nack),
    .o_sol_response (sol_response),
    .o_sol_timeout  (sol_timeout),
    .o_busy         (busy),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one clock cycle: inputs sampled at the closing edge, outputs expected during the cycle.
  typedef struct {
    logic        sf, cl;
    logic [31:0] n;
    logic        rdy, ack, nack;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  r;
    logic        t;
    logic [2:0]  s;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic sf, input logic cl, input logic [31:0] n,
                     input logic rdy, input logic ack, input logic nack,
                     input logic v, input logic [7:0] d, input logic [1:0] r,
                     input logic t, input logic [2:0] s);
    vec_t e;
    e.sf = sf; e.cl = cl; e.n = n; e.rdy = rdy; e.ack = ack; e.nack = nack;
    e.v = v; e.d = d; e.r = r; e.t = t; e.s = s;
    vq.push_back(e);
  endtask

  // Idle-input row with expected outputs only.
  task automatic q(input logic v, input logic [7:0] d, input logic [1:0] r,
                   input logic t, input logic [2:0] s);
    add(0, 0, 32'h0, 0, 0, 0, v, d, r, t, s);
  endtask

  function automatic logic [15:0] pack_out();
    return {tx_valid, tx_data, sol_response, sol_timeout, busy, state};
  endfunction

  function automatic logic [15:0] pack_exp(input logic v, input logic [7:0] d,
                                           input logic [1:0] r, input logic t,
                                           input logic [2:0] s);
    return {v, d, r, t, (s != 3'b000), s};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (v,data,resp,to,busy,state)", name, got, exp);
    end
  endtask

  task automatic build();
    // 1: DEADBEEF at full rate, ack 3 cycles after the last byte.
    add(0, 1, 32'hDEADBEEF, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 8'hDE, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'hAD, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'hBE, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'hEF, 0, 0, 2);
    q(0, 8'h00, 0, 0, 3);
    q(0, 8'h00, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 3);
    q(0, 8'h00, 2'b10, 0, 4);
    q(0, 8'h00, 0, 0, 0);
    // 2: stalls on SOF and every nonce byte.
    add(0, 1, 32'h01020304, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 8'h01, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h01, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 8'h02, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h02, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 8'h03, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h03, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 8'h04, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h04, 0, 0, 2);
    // 3a: no verdict -> timeout resume 9 cycles after entry.
    for (int i = 0; i < 8; i++) q(0, 8'h00, 0, 0, 3);
    q(0, 8'h00, 2'b01, 1, 4);
    // 3b: nack on counter 7 beats the timeout.
    add(0, 1, 32'h00000000, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 2);
    for (int i = 0; i < 7; i++) q(0, 8'h00, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 3);
    q(0, 8'h00, 2'b01, 0, 4);
    // 4: ack+nack together -> resume; claim held through RESPOND.
    add(0, 1, 32'h11223344, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 8'h11, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h22, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h33, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h44, 0, 0, 2);
    add(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 3);
    add(0, 1, 32'h55667788, 1, 0, 0, 0, 8'h00, 2'b01, 0, 4);
    add(0, 1, 32'h55667788, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    // 5: start_found while the second nonce byte is pending.
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 8'h55, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 1, 8'h66, 0, 0, 2);
    add(1, 1, 32'h99999999, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 32'hCAFEF00D, 1, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 8'hA5, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 8'hCA, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'hFE, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'hF0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 1, 8'h0D, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 3);
    q(0, 8'h00, 2'b10, 0, 4);
    q(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    n_rst = 1'b0; start_found = 0; sol_claim = 0; sol_nonce = '0;
    tx_ready = 0; host_ack = 0; host_nack = 0;
    build();
    #1 chk("reset_state", pack_out(), 16'h0000);
    #11 n_rst = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      start_found = vq[i].sf; sol_claim = vq[i].cl; sol_nonce = vq[i].n;
      tx_ready = vq[i].rdy; host_ack = vq[i].ack; host_nack = vq[i].nack;
      @(negedge clk);
      chk($sformatf("row%0d", i), pack_out(),
          pack_exp(vq[i].v, vq[i].d, vq[i].r, vq[i].t, vq[i].s));
      @(posedge clk); #1;
    end

    // 6: reset in WAIT_VERDICT, then a stray ack.
    start_found = 0; host_ack = 0; host_nack = 0;
    sol_claim = 1; sol_nonce = 32'h0BADF00D; tx_ready = 1;
    @(posedge clk); #1 sol_claim = 0;
    repeat (5) @(posedge clk);
    #1 chk("wait_before_rst", pack_out(), pack_exp(0, 8'h00, 0, 0, 3));
    #2 n_rst = 1'b0;
    #1 chk("async_rst", pack_out(), 16'h0000);
    @(posedge clk); #1 n_rst = 1'b1; host_ack = 1;
    @(posedge clk); #1 host_ack = 0;
    chk("ack_after_rst", pack_out(), 16'h0000);
    @(posedge clk); #1 chk("idle_after_rst", pack_out(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
